// File: rtl/axil_reg_slave_if.sv
// -----------------------------------------------------------------------------
// axil_reg_slave_if
// AXI4-lite bus bundle (single-beat subset with awlen/arlen/rlast carried along
// so the slave can sit directly on a full master-side signal set).
//
// Parameters:
//   ADDR_WIDTH  byte address width
//   DATA_WIDTH  data width (32 or 64)
//
// Modports:
//   master  drives aw/w/ar request channels and b/r ready
//   slave   drives the readies of aw/w/ar and the b/r response channels
// -----------------------------------------------------------------------------
interface axil_reg_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  // Write address channel
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [3:0]              awlen;

  // Write data channel
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;

  // Write response channel
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  // Read address channel
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [3:0]              arlen;

  // Read data channel
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  modport master (
    output awvalid, awaddr, awlen,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arlen,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awaddr, awlen,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arlen,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp, rlast
  );

endinterface

// File: rtl/axil_reg_slave.sv
// -----------------------------------------------------------------------------
// axil_reg_slave
// AXI4-lite slave register bank. NUM_REGS read/write registers are exposed to
// the fabric as a flat bus together with a one-cycle write pulse per register.
// Read and write channels run independent two-state FSMs; every transaction is
// a single beat (awlen/arlen are ignored).
//
// Parameters:
//   ADDR_WIDTH  byte address width
//   DATA_WIDTH  data width, 32 or 64
//   NUM_REGS    number of registers, 1..256
//   BASE_ADDR   byte address of register 0, aligned to DATA_WIDTH/8
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   bus       AXI4-lite slave modport (aw/w/b/ar/r channels)
//   reg_q     register contents, register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse  one-cycle pulse on the cycle register i is updated
//
// Optional feature (macro AXIL_REG_SLAVE_DECERR_EN):
//   defined   an address miss answers DECERR (2'b11) on bresp/rresp
//   undefined an address miss answers OKAY; the write is silently dropped
//   In both builds a read miss returns rdata = 0 and a write miss changes
//   nothing.
// -----------------------------------------------------------------------------
module axil_reg_slave #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  axil_reg_slave_if.slave                bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_SLAVE_DECERR_EN
  localparam logic [1:0] RESP_MISS = 2'b11;
`else
  localparam logic [1:0] RESP_MISS = 2'b00;
`endif

  typedef enum logic { W_COLLECT, W_RESP } w_state_e;
  typedef enum logic { R_IDLE,    R_DATA } r_state_e;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } decode_t;

  // Byte address -> register index. Addresses below BASE_ADDR wrap to a huge
  // offset after subtraction, so the explicit >= test is what rejects them.
  function automatic decode_t decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] word;
    decode_t               d;
    word  = (addr - BASE_ADDR) >> ADDR_LSB;
    d.hit = (addr >= BASE_ADDR) && (word < ADDR_WIDTH'(NUM_REGS));
    d.idx = word[IDX_W-1:0];
    return d;
  endfunction

  // ---------------------------------------------------------------------------
  // Register storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;

  // ---------------------------------------------------------------------------
  // Write channel state
  // ---------------------------------------------------------------------------
  w_state_e              w_state_q, w_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q,  w_held_d;
  logic                  awready_q, awready_d;
  logic                  wready_q,  wready_d;
  logic                  bvalid_q,  bvalid_d;
  logic [1:0]            bresp_q,   bresp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     wstrb_q;
  logic                  do_write;
  decode_t               wdec;

  // ---------------------------------------------------------------------------
  // Read channel state
  // ---------------------------------------------------------------------------
  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;
  decode_t               rdec;

  logic aw_hs, w_hs, ar_hs;

  assign aw_hs = bus.awvalid & awready_q;
  assign w_hs  = bus.wvalid  & wready_q;
  assign ar_hs = bus.arvalid & arready_q;

  assign wdec = decode(awaddr_q);
  assign rdec = decode(bus.araddr);

  // Burst length fields carry no meaning for a single-beat slave.
  logic unused_len;
  assign unused_len = ^{bus.awlen, bus.arlen};

  // ---------------------------------------------------------------------------
  // Write FSM: next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in this block gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    do_write  = 1'b0;

    case (w_state_q)
      W_COLLECT: begin
        // AW and W are collected independently; each ready falls the cycle
        // after its own handshake.
        aw_held_d = aw_held_q | aw_hs;
        w_held_d  = w_held_q  | w_hs;
        awready_d = ~aw_held_d;
        wready_d  = ~w_held_d;
        if (aw_held_q && w_held_q) begin
          w_state_d = W_RESP;
          bvalid_d  = 1'b1;
          bresp_d   = wdec.hit ? RESP_OKAY : RESP_MISS;
          do_write  = wdec.hit;
        end
      end

      W_RESP: begin
        awready_d = 1'b0;
        wready_d  = 1'b0;
        if (bus.bready) begin
          w_state_d = W_COLLECT;
          bvalid_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end

      default: w_state_d = W_COLLECT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write FSM: state register and captured payload
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_COLLECT;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      if (aw_hs) awaddr_q <= bus.awaddr;
      if (w_hs) begin
        wdata_q <= bus.wdata;
        wstrb_q <= bus.wstrb;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register bank update and write pulse
  // ---------------------------------------------------------------------------
  // NOTE: the register array is reset explicitly because its contents are
  // architecturally visible on reg_q; this keeps it in flops, not RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (do_write) begin
        // The pulse fires even when wstrb is all zero.
        wr_pulse_q[wdec.idx] <= 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_q[b]) regs[wdec.idx][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM: next state and outputs
  // ---------------------------------------------------------------------------
  // regs is sampled before the edge that may also commit a write, so a read
  // and write to one register on the same edge returns the old value.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;

    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          rdata_d   = rdec.hit ? regs[rdec.idx] : '0;
          rresp_d   = rdec.hit ? RESP_OKAY : RESP_MISS;
        end
      end

      R_DATA: begin
        if (bus.rready) begin
          r_state_d = R_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end

      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rvalid_q;

  assign wr_pulse = wr_pulse_q;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_axil_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_axil_reg_slave
// Directed and randomized bench for axil_reg_slave (default 32-bit, 16 regs,
// base 0). Expected values come from a register-array model updated byte by
// byte from the AXI rules. Build with AXIL_REG_SLAVE_DECERR_EN to expect
// DECERR on misses.
// -----------------------------------------------------------------------------
module tb_axil_reg_slave;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NR   = 16;
  localparam logic [31:0] BASE = 32'h0;
  localparam int          FW   = NR * DW;

`ifdef AXIL_REG_SLAVE_DECERR_EN
  localparam logic [1:0] MISS = 2'b11;
`else
  localparam logic [1:0] MISS = 2'b00;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [FW-1:0] reg_q;
  logic [NR-1:0] wr_pulse;

  axil_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_reg_slave #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .BASE_ADDR (BASE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .reg_q   (reg_q),
    .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] model [NR];

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) / 4) < NR);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [FW-1:0] m_flat();
    logic [FW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly,
                           input int w_dly, input int b_dly);
    bit            aw_got, w_got;
    int            c;
    logic [1:0]    exp_resp;
    logic [NR-1:0] exp_pulse;
    exp_resp  = m_hit(addr) ? 2'b00 : MISS;
    exp_pulse = m_hit(addr) ? (NR'(1) << m_idx(addr)) : '0;
    aw_got = 1'b0;
    w_got  = 1'b0;
    c      = 0;
    bus.bready = (b_dly == 0);
    while (!(aw_got && w_got) && c < 40) begin
      @(negedge clk);
      if (aw_got) check("awready_low_after_aw", bus.awready, 0);
      if (w_got)  check("wready_low_after_w", bus.wready, 0);
      bus.awvalid = !aw_got && (c >= aw_dly);
      bus.awaddr  = addr;
      bus.awlen   = 4'($urandom);
      bus.wvalid  = !w_got && (c >= w_dly);
      bus.wdata   = data;
      bus.wstrb   = strb;
      if (bus.awvalid && bus.awready) aw_got = 1'b1;
      if (bus.wvalid && bus.wready)   w_got  = 1'b1;
      c++;
    end
    check("write_handshake_budget", aw_got && w_got, 1);
    if (m_hit(addr))
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[m_idx(addr)][b*8 +: 8] = data[b*8 +: 8];
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("bvalid_not_early", bus.bvalid, 0);
    @(negedge clk);
    check("bvalid", bus.bvalid, 1);
    check("bresp", bus.bresp, exp_resp);
    check("wr_pulse", wr_pulse, exp_pulse);
    check("reg_q_after_write", reg_q, m_flat());
    for (int k = 0; k < b_dly; k++) begin
      // A stray AW during the response phase must not be accepted.
      bus.awvalid = 1'b1;
      bus.awaddr  = 32'h30;
      @(negedge clk);
      check("bvalid_hold", bus.bvalid, 1);
      check("bresp_hold", bus.bresp, exp_resp);
      check("no_aw_in_resp", bus.awready, 0);
      check("wr_pulse_single", wr_pulse, 0);
    end
    bus.awvalid = 1'b0;
    bus.bready  = 1'b1;
    @(negedge clk);
    check("bvalid_cleared", bus.bvalid, 0);
    check("ready_restored", {bus.awready, bus.wready}, 2'b11);
    check("wr_pulse_done", wr_pulse, 0);
    check("reg_q_stable", reg_q, m_flat());
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_dly,
                          output logic [31:0] got);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = m_hit(addr) ? model[m_idx(addr)] : 32'h0;
    exp_resp = m_hit(addr) ? 2'b00 : MISS;
    @(negedge clk);
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    bus.arlen   = 4'($urandom);
    bus.rready  = (r_dly == 0);
    check("arready_idle", bus.arready, 1);
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("rvalid", bus.rvalid, 1);
    check("rlast", bus.rlast, 1);
    check("rdata", bus.rdata, exp_data);
    check("rresp", bus.rresp, exp_resp);
    check("arready_busy", bus.arready, 0);
    got = bus.rdata;
    for (int k = 0; k < r_dly; k++) begin
      @(negedge clk);
      check("rvalid_hold", bus.rvalid, 1);
      check("rdata_hold", bus.rdata, exp_data);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    check("rvalid_cleared", {bus.rvalid, bus.rlast}, 2'b00);
    check("arready_restored", bus.arready, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0]   got;
    logic [FW-1:0] snap;

    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
    bus.bready  = 1'b1;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0;
    bus.rready  = 1'b1;
    for (int i = 0; i < NR; i++) model[i] = '0;

    // ---- reset ----
    repeat (5) @(negedge clk);
    check("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check("rst_valids", {bus.bvalid, bus.rvalid, bus.rlast}, 3'b000);
    check("rst_resp", {bus.bresp, bus.rresp}, 4'h0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_reg_q", reg_q, 0);
    rst_n = 1'b1;
    #1;
    check("readies_before_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
    @(negedge clk);
    check("readies_after_release", {bus.awready, bus.wready, bus.arready}, 3'b111);
    check("reg_q_after_release", reg_q, 0);

    // ---- write then read back ----
    axi_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check("reg2_deadbeef", reg_q[2*DW +: DW], 32'hDEADBEEF);
    axi_read(32'h8, 0, got);
    check("readback_deadbeef", got, 32'hDEADBEEF);

    // ---- byte strobes ----
    axi_write(32'hC, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(32'hC, 32'hAABBCCDD, 4'h5, 0, 0, 0);
    check("reg3_strobed", reg_q[3*DW +: DW], 32'h11BB33DD);

    // ---- AW/W ordering with stalled response ----
    axi_write(32'h10, 32'h12345678, 4'hF, 4, 0, 6);
    axi_write(32'h14, 32'h0BADF00D, 4'hF, 0, 3, 6);
    check("reg4_w_first", reg_q[4*DW +: DW], 32'h12345678);
    check("reg5_aw_first", reg_q[5*DW +: DW], 32'h0BADF00D);
    check("reg12_untouched", reg_q[12*DW +: DW], 0);

    // ---- zero strobe still pulses ----
    axi_write(32'h18, 32'hFFFFFFFF, 4'h0, 1, 1, 0);
    check("reg6_zero_strb", reg_q[6*DW +: DW], 0);

    // ---- out of range ----
    snap = reg_q;
    axi_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 1);
    check("miss_no_change", reg_q, snap);
    axi_read(32'h40, 2, got);
    check("miss_rdata_zero", got, 0);
    axi_write(32'h3F, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    axi_read(32'h3C, 0, got);
    check("last_reg_unaligned", got, 32'hA5A5A5A5);

    // ---- overlapping read and write to reg 1 ----
    axi_write(32'h4, 32'h5, 4'hF, 0, 0, 0);
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = 32'h4;
    bus.wvalid  = 1'b1; bus.wdata  = 32'h9; bus.wstrb = 4'hF;
    bus.bready  = 1'b1; bus.rready = 1'b1;
    check("ovl_ready", {bus.awready, bus.wready}, 2'b11);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.arvalid = 1'b1; bus.araddr = 32'h4;
    @(negedge clk);
    bus.arvalid = 1'b0;
    model[1] = 32'h9;
    check("ovl_rdata_old", bus.rdata, 32'h5);
    check("ovl_valids", {bus.rvalid, bus.bvalid}, 2'b11);
    check("ovl_reg1_new", reg_q[1*DW +: DW], 32'h9);
    @(negedge clk);
    check("ovl_done", {bus.rvalid, bus.bvalid}, 2'b00);

    // ---- reset during a stalled read ----
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = 32'h8; bus.rready = 1'b0;
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("pre_reset_rvalid", bus.rvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rvalid_clear", {bus.rvalid, bus.rlast}, 2'b00);
    check("async_reg_q_clear", reg_q, 0);
    for (int i = 0; i < NR; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale_beat", bus.rvalid, 0);
    end
    check("arready_after_reset", bus.arready, 1);
    bus.rready = 1'b1;

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 32'h4F));
      if ($urandom_range(0, 1) == 0)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2), got);
    end

    // ---- final sweep ----
    for (int i = 0; i < NR; i++) axi_read(BASE + 32'(i * 4), 0, got);
    check("final_reg_q", reg_q, m_flat());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
